// File: rtl/matrix_pkg.sv
// Shared sizing constants for the matrix-calc datapath.
package matrix_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned RESULT_W   = 64;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned MAT_DIM    = 16;
    localparam int unsigned IDX_W      = $clog2(MAT_DIM) + 1;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
interface sync_fifo_if #(
    parameter int unsigned WIDTH = matrix_pkg::DATA_W
);

    logic [WIDTH-1:0] d;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] q;
    logic             full;
    logic             empty;

    modport master (output d, wr, rd, input  q, full, empty);
    modport slave  (input  d, wr, rd, output q, full, empty);

endinterface

// File: rtl/rc_index_counter.sv
// Row/column walker over a matrix; column advances per update and carries into row.
module rc_index_counter
    import matrix_pkg::*;
#(
    parameter int unsigned COL_WIDTH = IDX_W,
    parameter int unsigned ROW_WIDTH = IDX_W,
    parameter int unsigned COL_SIZE  = MAT_DIM,
    parameter int unsigned ROW_SIZE  = MAT_DIM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 update,
    output logic [COL_WIDTH-1:0] col_idx,
    output logic [ROW_WIDTH-1:0] row_idx
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_idx <= '0;
            row_idx <= '0;
        end else if (update) begin
            if (col_idx == COL_WIDTH'(COL_SIZE - 1)) begin
                col_idx <= '0;
                if (row_idx == ROW_WIDTH'(ROW_SIZE - 1)) row_idx <= '0;
                else                                     row_idx <= row_idx + ROW_WIDTH'(1);
            end else begin
                col_idx <= col_idx + COL_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is always presented on q.
module sync_fifo
    import matrix_pkg::*;
#(
    parameter  int unsigned WIDTH = DATA_W,
    parameter  int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_fifo_if.slave  fifo_if
);

    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    // A full FIFO still accepts a write when the same cycle pops.
    assign w_pop  = fifo_if.rd & ~r_empty;
    assign w_push = fifo_if.wr & (~r_full | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are registered from the next count so they never see storage X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= fifo_if.d;
    end

    assign fifo_if.q     = r_mem[r_rptr];
    assign fifo_if.full  = r_full;
    assign fifo_if.empty = r_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (table vectors plus corner sequences) and rc_index_counter.
module tb_sync_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic update = 1'b0;
    logic [4:0] col_idx;
    logic [4:0] row_idx;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo_if #(.WIDTH(32)) fif ();

    sync_fifo #(.WIDTH(32), .DEPTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fifo_if (fif)
    );

    rc_index_counter #(.COL_WIDTH(5), .ROW_WIDTH(5), .COL_SIZE(16), .ROW_SIZE(16)) u_rc (
        .clk     (clk),
        .rst_n   (rst_n),
        .update  (update),
        .col_idx (col_idx),
        .row_idx (row_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] d;
        logic        exp_empty;
        logic        exp_full;
        logic        chk_q;
        logic [31:0] exp_q;
    } vec_t;

    vec_t vecs [12];
    logic [31:0] mq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        fif.wr = 1'b1; fif.rd = 1'b0; fif.d = v;
        step();
        fif.wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        logic pop_e, push_e;

        // inputs, then expected flags/q observed before the edge that applies them
        vecs[0]  = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11};
        vecs[2]  = '{1'b1, 1'b0, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11};
        vecs[3]  = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 32'h11};
        vecs[4]  = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 32'h22};
        vecs[5]  = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 32'h33};
        vecs[6]  = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h44};
        vecs[9]  = '{1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h44};
        vecs[10] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 32'h55};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0};

        fif.wr = 1'b0; fif.rd = 1'b0; fif.d = '0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // Reset then idle with rd pulses
        for (int i = 0; i < 10; i++) begin
            fif.rd = i[0];
            #1;
            chk("idle_empty", 64'(fif.empty), 64'd1);
            chk("idle_full", 64'(fif.full), 64'd0);
            step();
        end
        fif.rd = 1'b0;
        chk("idle_count", 64'(dut.r_count), 64'd0);

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            fif.wr = vecs[i].wr; fif.rd = vecs[i].rd; fif.d = vecs[i].d;
            #1;
            chk($sformatf("vec%0d_empty", i), 64'(fif.empty), 64'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_full", i), 64'(fif.full), 64'(vecs[i].exp_full));
            if (vecs[i].chk_q) chk($sformatf("vec%0d_q", i), 64'(fif.q), 64'(vecs[i].exp_q));
            step();
        end
        fif.wr = 1'b0; fif.rd = 1'b0;

        // Fill to full, dropped overflow write, drain
        for (int i = 0; i < 16; i++) begin
            chk("fill_full_lo", 64'(fif.full), 64'd0);
            push(32'(i));
        end
        chk("fill_full", 64'(fif.full), 64'd1);
        push(32'hDEAD);
        chk("ovf_full", 64'(fif.full), 64'd1);
        chk("ovf_count", 64'(dut.r_count), 64'd16);
        chk("ovf_head", 64'(fif.q), 64'd0);
        fif.rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_q", 64'(fif.q), 64'(i));
            chk("drain_empty", 64'(fif.empty), 64'd0);
            step();
        end
        fif.rd = 1'b0;
        chk("drain_done_empty", 64'(fif.empty), 64'd1);

        // Simultaneous wr/rd while full
        for (int i = 0; i < 16; i++) push(32'(i));
        fif.wr = 1'b1; fif.rd = 1'b1; fif.d = 32'h99;
        chk("fwr_q_before", 64'(fif.q), 64'd0);
        step();
        fif.wr = 1'b0; fif.rd = 1'b0;
        chk("fwr_full", 64'(fif.full), 64'd1);
        chk("fwr_q_after", 64'(fif.q), 64'd1);
        fif.rd = 1'b1;
        for (int i = 1; i < 17; i++) begin
            chk("fwr_drain_q", 64'(fif.q), (i == 16) ? 64'h99 : 64'(i));
            step();
        end
        fif.rd = 1'b0;
        chk("fwr_drain_empty", 64'(fif.empty), 64'd1);

        // Streaming with a mid-stream reset, checked against a queue model
        mq.delete();
        for (int i = 0; i < 100; i++) begin
            fif.wr = 1'b1; fif.d = 32'h1000 + 32'(i); fif.rd = (i % 3 != 0);
            #1;
            chk("str_empty", 64'(fif.empty), 64'(mq.size() == 0));
            chk("str_full", 64'(fif.full), 64'(mq.size() == 16));
            if (fif.rd && mq.size() > 0) chk("str_q", 64'(fif.q), 64'(mq[0]));
            if (i == 60) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                mq.delete();
                chk("rst_empty", 64'(fif.empty), 64'd1);
                chk("rst_full", 64'(fif.full), 64'd0);
                chk("rst_count", 64'(dut.r_count), 64'd0);
            end else begin
                pop_e  = fif.rd && (mq.size() > 0);
                push_e = (mq.size() < 16) || pop_e;
                step();
                if (pop_e)  void'(mq.pop_front());
                if (push_e) mq.push_back(fif.d);
            end
        end
        fif.wr = 1'b0; fif.rd = 1'b1;
        for (int i = 0; i < 20 && mq.size() > 0; i++) begin
            chk("str_drain_q", 64'(fif.q), 64'(mq[0]));
            void'(mq.pop_front());
            step();
        end
        fif.rd = 1'b0;
        chk("str_final_empty", 64'(fif.empty), 64'd1);

        // Row/column counter
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rc_rst_col", 64'(col_idx), 64'd0);
        chk("rc_rst_row", 64'(row_idx), 64'd0);
        update = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("rc_col_seq", 64'(col_idx), 64'(i));
            step();
        end
        chk("rc16_col", 64'(col_idx), 64'd0);
        chk("rc16_row", 64'(row_idx), 64'd1);
        for (int i = 16; i < 256; i++) step();
        chk("rc256_col", 64'(col_idx), 64'd0);
        chk("rc256_row", 64'(row_idx), 64'd0);
        step(); step(); step();
        update = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rc_hold_col", 64'(col_idx), 64'd3);
            chk("rc_hold_row", 64'(row_idx), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
